// File: rtl/trena_pkg.sv
// Shared definitions for the trena measurement path: sequencer state codes
// and the ASCII characters used in the serial report.
package trena_pkg;

    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        DISPARA       = 4'd1,
        ESPERA_MEDIDA = 4'd2,
        ARMAZENA      = 4'd3,
        TRANSMITE     = 4'd4,
        ESPERA_TX     = 4'd5,
        PROXIMO       = 4'd6,
        FINAL         = 4'd7
    } estado_t;

    localparam logic [6:0] ASCII_HASH     = 7'h23;
    localparam logic [6:0] ASCII_TRACO    = 7'h2D;
    localparam logic [6:0] ASCII_INTERROG = 7'h3F;
    localparam logic [6:0] ASCII_ZERO     = 7'h30;

endpackage

// File: rtl/bcd_para_ascii.sv
// Converts one BCD digit to its 7-bit ASCII character; non-decimal nibbles
// are reported as '?'.
module bcd_para_ascii
    import trena_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] ascii
);

    always_comb begin
        if (bcd <= 4'd9) begin
            ascii = {ASCII_ZERO[6:4], bcd};
        end else begin
            ascii = ASCII_INTERROG;
        end
    end

endmodule

// File: rtl/medida_tx_sequencer.sv
// Trena controller: triggers one HC-SR04 measurement per mensurar pulse and
// reports the 3-digit result over tx_serial_7O1 as "<c><d><u>#".
module medida_tx_sequencer
    import trena_pkg::*;
#(
    parameter int TIMEOUT_CICLOS  = 3000000,
    parameter int LARGURA_TIMEOUT = 22
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mensurar,
    input  logic        medida_pronto,
    input  logic [11:0] medida,
    input  logic        tx_pronto,
    output logic        sensor_mensurar,
    output logic        tx_partida,
    output logic [6:0]  tx_dados_ascii,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado
);

    localparam logic [LARGURA_TIMEOUT-1:0] LIMITE = LARGURA_TIMEOUT'(TIMEOUT_CICLOS - 1);

    estado_t estado, proximo;

    logic [LARGURA_TIMEOUT-1:0] contador;
    logic [1:0] indice, indice_prox;
    logic [6:0] car_centena, car_dezena, car_unidade;
    logic [6:0] asc_centena, asc_dezena, asc_unidade;
    logic [6:0] car_sel;
    logic       limite_atingido;

    bcd_para_ascii u_conv_centena (.bcd(medida[11:8]), .ascii(asc_centena));
    bcd_para_ascii u_conv_dezena  (.bcd(medida[7:4]),  .ascii(asc_dezena));
    bcd_para_ascii u_conv_unidade (.bcd(medida[3:0]),  .ascii(asc_unidade));

    assign limite_atingido = (contador == LIMITE);
    assign db_estado       = estado;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo         = estado;
        indice_prox     = indice;
        sensor_mensurar = 1'b0;
        tx_partida      = 1'b0;
        pronto          = 1'b0;
        case (estado)
            INICIAL: begin
                if (mensurar) proximo = DISPARA;
            end
            DISPARA: begin
                sensor_mensurar = 1'b1;
                proximo         = ESPERA_MEDIDA;
            end
            ESPERA_MEDIDA: begin
                if (medida_pronto || limite_atingido) proximo = ARMAZENA;
            end
            ARMAZENA: begin
                indice_prox = 2'd0;
                proximo     = TRANSMITE;
            end
            TRANSMITE: begin
                tx_partida = 1'b1;
                proximo    = ESPERA_TX;
            end
            ESPERA_TX: begin
                if (tx_pronto) proximo = PROXIMO;
            end
            PROXIMO: begin
                if (indice == 2'd3) begin
                    proximo = FINAL;
                end else begin
                    indice_prox = indice + 2'd1;
                    proximo     = TRANSMITE;
                end
            end
            FINAL: begin
                pronto  = 1'b1;
                proximo = INICIAL;
            end
            default: proximo = INICIAL;
        endcase
    end

    // Selected from the next index so the character is already registered
    // on the first cycle of TRANSMITE.
    always_comb begin
        case (indice_prox)
            2'd0:    car_sel = car_centena;
            2'd1:    car_sel = car_dezena;
            2'd2:    car_sel = car_unidade;
            default: car_sel = ASCII_HASH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contador       <= '0;
            indice         <= '0;
            car_centena    <= '0;
            car_dezena     <= '0;
            car_unidade    <= '0;
            erro           <= 1'b0;
            tx_dados_ascii <= '0;
        end else begin
            indice <= indice_prox;

            if (estado == DISPARA) begin
                contador <= '0;
            end else if (estado == ESPERA_MEDIDA) begin
                contador <= contador + 1'b1;
            end

            if (estado == INICIAL && mensurar) begin
                erro <= 1'b0;
            end

            // A result arriving on the timeout cycle takes priority.
            if (estado == ESPERA_MEDIDA) begin
                if (medida_pronto) begin
                    car_centena <= asc_centena;
                    car_dezena  <= asc_dezena;
                    car_unidade <= asc_unidade;
                end else if (limite_atingido) begin
                    erro        <= 1'b1;
                    car_centena <= ASCII_TRACO;
                    car_dezena  <= ASCII_TRACO;
                    car_unidade <= ASCII_TRACO;
                end
            end

            if (proximo == TRANSMITE) begin
                tx_dados_ascii <= car_sel;
            end
        end
    end

endmodule

// File: tb/tb_medida_tx_sequencer.sv
// Directed bench for medida_tx_sequencer with a small transmitter responder
// and an event monitor that logs pulses, characters and the state trace.
module tb_medida_tx_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        mensurar;
    logic        medida_pronto;
    logic [11:0] medida;
    logic        tx_pronto;
    logic        tx_pronto_model;
    logic        tx_pronto_spur;
    logic        sensor_mensurar;
    logic        tx_partida;
    logic [6:0]  tx_dados_ascii;
    logic        pronto;
    logic        erro;
    logic [3:0]  db_estado;

    int checks = 0;
    int errors = 0;

    int n_sensor, n_partida, n_pronto, n_espera;
    logic [6:0] chars[$];
    logic [3:0] trace[$];
    logic [3:0] last_estado;

    assign tx_pronto = tx_pronto_model | tx_pronto_spur;

    medida_tx_sequencer #(
        .TIMEOUT_CICLOS (100),
        .LARGURA_TIMEOUT(22)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .mensurar       (mensurar),
        .medida_pronto  (medida_pronto),
        .medida         (medida),
        .tx_pronto      (tx_pronto),
        .sensor_mensurar(sensor_mensurar),
        .tx_partida     (tx_partida),
        .tx_dados_ascii (tx_dados_ascii),
        .pronto         (pronto),
        .erro           (erro),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset) begin
            if (sensor_mensurar) n_sensor++;
            if (tx_partida)      n_partida++;
            if (pronto)          n_pronto++;
            if (db_estado == 4'd2) n_espera++;
            if (db_estado != last_estado) begin
                trace.push_back(db_estado);
                last_estado = db_estado;
            end
        end
    end

    // Transmitter stand-in: accepts a character and reports end of frame later.
    initial begin
        tx_pronto_model = 1'b0;
        forever begin
            @(negedge clock);
            if (tx_partida && !reset) begin
                chars.push_back(tx_dados_ascii);
                repeat (9) @(negedge clock);
                tx_pronto_model = 1'b1;
                @(negedge clock);
                tx_pronto_model = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        n_sensor  = 0;
        n_partida = 0;
        n_pronto  = 0;
        n_espera  = 0;
        chars.delete();
        trace.delete();
        trace.push_back(4'd0);
        last_estado = 4'd0;
    endtask

    task automatic run(input logic [11:0] val, input int delay, input bit give, input bit busy);
        int n;
        mensurar = 1'b1;
        @(negedge clock);
        mensurar = 1'b0;
        check("sensor_latency", {31'd0, sensor_mensurar}, 32'd1);
        check("erro_cleared", {31'd0, erro}, 32'd0);
        for (int i = 0; i < delay; i++) begin
            @(negedge clock);
            mensurar = (busy && i == delay / 2) ? 1'b1 : 1'b0;
        end
        if (give) begin
            medida        = val;
            medida_pronto = 1'b1;
            @(negedge clock);
            medida_pronto = 1'b0;
            check("armazena_state", {28'd0, db_estado}, 32'd3);
            @(negedge clock);
            check("partida_latency", {31'd0, tx_partida}, 32'd1);
        end
        if (busy) begin
            n = 0;
            while (db_estado != 4'd5 && n < 500) begin
                @(negedge clock);
                n++;
            end
            check("busy_reach_espera_tx", {28'd0, db_estado}, 32'd5);
            mensurar = 1'b1;
            @(negedge clock);
            mensurar = 1'b0;
        end
        n = 0;
        while (!pronto && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check("pronto_seen", {31'd0, pronto}, 32'd1);
        repeat (3) @(negedge clock);
    endtask

    task automatic verify(input string tag, input logic [6:0] c0, input logic [6:0] c1,
                          input logic [6:0] c2, input logic exp_erro);
        logic [6:0] exp_c[4];
        exp_c[0] = c0;
        exp_c[1] = c1;
        exp_c[2] = c2;
        exp_c[3] = 7'h23;
        check({tag, "_nchars"}, chars.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < chars.size())
                check($sformatf("%s_char%0d", tag, i), {25'd0, chars[i]}, {25'd0, exp_c[i]});
        end
        check({tag, "_n_sensor"}, n_sensor, 32'd1);
        check({tag, "_n_partida"}, n_partida, 32'd4);
        check({tag, "_n_pronto"}, n_pronto, 32'd1);
        check({tag, "_erro"}, {31'd0, erro}, {31'd0, exp_erro});
        check({tag, "_ascii_held"}, {25'd0, tx_dados_ascii}, 32'h23);
        check({tag, "_idle"}, {28'd0, db_estado}, 32'd0);
    endtask

    initial begin
        logic [3:0] exp_trace[18];
        int n;

        reset          = 1'b1;
        mensurar       = 1'b0;
        medida_pronto  = 1'b0;
        medida         = '0;
        tx_pronto_spur = 1'b0;
        clear_log();
        repeat (2) @(negedge clock);
        check("rst_sensor", {31'd0, sensor_mensurar}, 32'd0);
        check("rst_partida", {31'd0, tx_partida}, 32'd0);
        check("rst_ascii", {25'd0, tx_dados_ascii}, 32'd0);
        check("rst_pronto", {31'd0, pronto}, 32'd0);
        check("rst_erro", {31'd0, erro}, 32'd0);
        check("rst_estado", {28'd0, db_estado}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Nominal
        clear_log();
        run(12'h123, 20, 1'b1, 1'b0);
        verify("nom", 7'h31, 7'h32, 7'h33, 1'b0);
        exp_trace[0] = 4'd0; exp_trace[1] = 4'd1; exp_trace[2] = 4'd2; exp_trace[3] = 4'd3;
        for (int k = 0; k < 4; k++) begin
            exp_trace[4 + 3 * k] = 4'd4;
            exp_trace[5 + 3 * k] = 4'd5;
            exp_trace[6 + 3 * k] = 4'd6;
        end
        exp_trace[16] = 4'd7; exp_trace[17] = 4'd0;
        check("nom_trace_len", trace.size(), 32'd18);
        for (int k = 0; k < 18; k++) begin
            if (k < trace.size())
                check($sformatf("nom_trace%0d", k), {28'd0, trace[k]}, {28'd0, exp_trace[k]});
        end

        // Timeout
        clear_log();
        run(12'h777, 0, 1'b0, 1'b0);
        verify("tmo", 7'h2D, 7'h2D, 7'h2D, 1'b1);
        check("tmo_wait_cycles", n_espera, 32'd100);

        // Tie on the timeout cycle (also checks erro cleared by mensurar)
        clear_log();
        run(12'h045, 100, 1'b1, 1'b0);
        verify("tie", 7'h30, 7'h34, 7'h35, 1'b0);

        // Busy / spurious
        clear_log();
        tx_pronto_spur = 1'b1;
        @(negedge clock);
        tx_pronto_spur = 1'b0;
        @(negedge clock);
        check("spur_tx_idle", {28'd0, db_estado}, 32'd0);
        run(12'h123, 20, 1'b1, 1'b1);
        verify("busy", 7'h31, 7'h32, 7'h33, 1'b0);

        // Invalid BCD
        clear_log();
        run(12'h9A0, 20, 1'b1, 1'b0);
        verify("inv", 7'h39, 7'h3F, 7'h30, 1'b0);

        // Reset in the middle of the second character
        clear_log();
        mensurar = 1'b1;
        @(negedge clock);
        mensurar = 1'b0;
        repeat (20) @(negedge clock);
        medida        = 12'h123;
        medida_pronto = 1'b1;
        @(negedge clock);
        medida_pronto = 1'b0;
        n = 0;
        while (!(n_partida >= 2 && db_estado == 4'd5) && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("mid_reach_second_char", {28'd0, db_estado}, 32'd5);
        #2 reset = 1'b1;
        #1;
        check("async_rst_estado", {28'd0, db_estado}, 32'd0);
        check("async_rst_ascii", {25'd0, tx_dados_ascii}, 32'd0);
        check("async_rst_partida", {31'd0, tx_partida}, 32'd0);
        check("async_rst_sensor", {31'd0, sensor_mensurar}, 32'd0);
        check("async_rst_pronto", {31'd0, pronto}, 32'd0);
        check("async_rst_erro", {31'd0, erro}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (15) @(negedge clock);
        clear_log();
        run(12'h123, 20, 1'b1, 1'b0);
        verify("rst", 7'h31, 7'h32, 7'h33, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
